// File: rtl/key_filter.sv
// rtl/key_filter.sv - play-button synchroniser/debouncer with press/release pulses and debounced level.
// Long-press detection is built only when KEY_FILTER_LONG_PRESS_EN is defined; otherwise long_flag is 0.
module key_filter #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_flag,
    output logic key_release,
    output logic long_flag
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        FILTER_DN = 2'b01,
        DOWN      = 2'b11,
        FILTER_UP = 2'b10
    } state_t;

    localparam logic [23:0] DB_LAST = 24'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || DB_CYCLES > ((1 << 24) - 1) ||
        LONG_CYCLES < 2 || LONG_CYCLES > ((1 << 26) - 1)) begin : g_bad_params
        $error("key_filter: DB_CYCLES or LONG_CYCLES out of range");
    end

    logic        s1_q;
    logic        key_sync_q;
    state_t      state_q;
    logic [23:0] db_cnt_q;
    logic        key_state_q;
    logic        key_flag_q;
    logic        key_release_q;
    logic        db_at_last;

    // Sync flops reset high so a held key is not seen until a full debounce after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            s1_q       <= key_in;
            key_sync_q <= s1_q;
        end
    end

    assign db_at_last = (db_cnt_q == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            db_cnt_q      <= '0;
            key_state_q   <= 1'b1;
            key_flag_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_flag_q    <= 1'b0;
            key_release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!key_sync_q) begin
                        state_q  <= FILTER_DN;
                        db_cnt_q <= '0;
                    end
                end
                FILTER_DN: begin
                    if (key_sync_q) begin
                        state_q  <= IDLE;
                        db_cnt_q <= '0;
                    end else if (db_at_last) begin
                        state_q     <= DOWN;
                        db_cnt_q    <= '0;
                        key_flag_q  <= 1'b1;
                        key_state_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 24'd1;
                    end
                end
                DOWN: begin
                    if (key_sync_q) begin
                        state_q  <= FILTER_UP;
                        db_cnt_q <= '0;
                    end
                end
                FILTER_UP: begin
                    if (!key_sync_q) begin
                        state_q  <= DOWN;
                        db_cnt_q <= '0;
                    end else if (db_at_last) begin
                        state_q       <= IDLE;
                        db_cnt_q      <= '0;
                        key_release_q <= 1'b1;
                        key_state_q   <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    db_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef KEY_FILTER_LONG_PRESS_EN
    localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);

    logic [25:0] long_cnt_q;
    logic        long_flag_q;
    logic        press_done;

    assign press_done = (state_q == FILTER_DN) && !key_sync_q && db_at_last;

    // Counter runs one past LONG_LAST and parks there, giving a single pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_q  <= '0;
            long_flag_q <= 1'b0;
        end else begin
            long_flag_q <= 1'b0;
            if (press_done) begin
                long_cnt_q <= '0;
            end else begin
                case (state_q)
                    DOWN: begin
                        if (long_cnt_q == LONG_LAST) begin
                            long_flag_q <= 1'b1;
                            long_cnt_q  <= long_cnt_q + 26'd1;
                        end else if (long_cnt_q < LONG_LAST) begin
                            long_cnt_q <= long_cnt_q + 26'd1;
                        end
                    end
                    FILTER_UP: long_cnt_q <= long_cnt_q;
                    default:   long_cnt_q <= '0;
                endcase
            end
        end
    end

    assign long_flag = long_flag_q;
`else
    assign long_flag = 1'b0;
`endif

    assign key_state   = key_state_q;
    assign key_flag    = key_flag_q;
    assign key_release = key_release_q;

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Front-end conditioning stage for the mechanical play button of the music player.
- Sits directly upstream of the player FSM and produces clean, glitch-free key events.
- Functions: synchronises the raw active-low key, debounces it with a counter-based FSM, emits one-cycle press/release pulses and a debounced level, and optionally flags a long press.

Parameters:
- DB_CYCLES, 1_000_000: stable-level cycles required to confirm a transition (20 ms at 50 MHz); legal range 2..2^24-1.
- LONG_CYCLES, 50_000_000: cycles held after confirmed press before long_flag fires (1 s at 50 MHz); legal range 2..2^26-1.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous reset, active-low
- key_in  input  1  raw button, active-low, asynchronous to clk
- key_state  output  1  debounced level, active-low (1 = released)
- key_flag  output  1  one-cycle pulse on confirmed press
- key_release  output  1  one-cycle pulse on confirmed release
- long_flag  output  1  one-cycle pulse on long press (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: key_state=1, key_flag=0, key_release=0, long_flag=0. Sync FFs reset to 1, so release of reset never produces a false press. State=IDLE, all counters 0.
- Synchroniser: 2-FF, key_in -> s1 -> key_sync. Only key_sync is used downstream.
- Debounce counter: 24-bit db_cnt.
- FSM states and transitions:
  - IDLE (stable released): key_sync==0 -> FILTER_DN, db_cnt<=0.
  - FILTER_DN:
    - key_sync==1 -> IDLE, db_cnt<=0, no pulse.
    - Else if db_cnt==DB_CYCLES-1 -> DOWN, key_flag<=1 for one cycle, key_state<=0.
    - Else db_cnt+1.
  - DOWN (stable pressed): key_sync==1 -> FILTER_UP, db_cnt<=0.
  - FILTER_UP:
    - key_sync==0 -> DOWN, no pulse.
    - Else if db_cnt==DB_CYCLES-1 -> IDLE, key_release<=1 for one cycle, key_state<=1.
    - Else db_cnt+1.
  - Illegal state encoding -> IDLE on next edge.
- Latency: key_flag is registered exactly DB_CYCLES+2 clock edges after the edge that first samples key_in low, provided key_in stays low throughout. key_release follows the same timing for release.
- Glitch rejection:
  - Any bounce shorter than DB_CYCLES cycles (as seen at key_sync) yields no pulse and no key_state change.
  - Each bounce restarts the filter from 0.
- Pulse rules:
  - key_flag, key_release and long_flag are never high in the same cycle.
  - Exactly one key_flag per confirmed press and one key_release per confirmed release; strict alternation starting with key_flag.
- Reset mid-operation (any state): immediate return to reset values. A key still held at reset release is re-detected as a new press after full debounce.
- No counter wrap: db_cnt never exceeds DB_CYCLES-1.

Optional Feature:
- Macro: KEY_FILTER_LONG_PRESS_EN.
- Defined:
  - 26-bit long_cnt is cleared on entry to DOWN and increments each cycle in DOWN.
  - When long_cnt==LONG_CYCLES-1, long_flag pulses for one cycle and long_cnt saturates, so only one long_flag per press.
  - long_cnt holds during FILTER_UP.
  - long_cnt clears when the FSM reaches IDLE, or on a bounce return from FILTER_UP to DOWN only if key_release has fired; otherwise it resumes. In practice it clears only on IDLE.
  - long_flag never fires after key_release.
- Undefined: no long_cnt logic; long_flag tied to 0.

Test Plan (DB_CYCLES=8, LONG_CYCLES=40 unless noted):
- Reset with key_in=0 held, release rst_n -> no pulse for 1 cycle, then key_flag high exactly 10 edges after the first sampling edge; key_state=0 afterwards.
- Clean press: key_in 1->0 and held 30 cycles -> single key_flag at edge +10; release held -> single key_release at edge +10 after the release sample; key_state returns to 1.
- Bounce: key_in low for 5 cycles, high 3, low 4, high, then stable high -> no key_flag or key_release; key_state stays 1 throughout.
- Release bounce: while in DOWN, key_in high 6 cycles then low again -> no key_release; key_state stays 0; later stable release -> exactly one key_release.
- Long press (macro defined): hold key_in low 100 cycles -> key_flag at +10, long_flag exactly once 40 cycles after key_flag, then key_release on release. Macro undefined -> long_flag constant 0.
- Reset mid-filter: assert rst_n=0 while db_cnt=5 in FILTER_DN -> all outputs at reset values within the same cycle (asynchronous); after deassert with key_in high -> no pulses.
